rrom_frontend: RTL and testbench
================================

// Module: rrom_frontend
// PURPOSE
//  TileLink-UL slave front end of the remote ROM (r_rom). Accepts one Get on
//  channel A, serialises its 64-bit address byte-wise into a command FIFO,
//  then collects 8 response bytes from a response FIFO into a 64-bit word.
//  That word is returned as AccessAckData on channel D. It sits between the
//  system bus and the byte-wide link to the remote ROM. One request in flight.
// PARAMETERS
//  ADDR_W  64  TileLink address width; address is sent as ADDR_W/8 bytes.
//  DATA_W  64  TileLink data width; response is DATA_W/8 bytes.
// PORTS
//  clk    in   1       single clock domain, rising edge
//  rst_n  in   1       asynchronous, active-low reset
//  bus    tilelink     slave modport, signals used:
//                      a_valid, a_ready, a_opcode, a_address, a_source, a_size,
//                      d_valid, d_ready, d_opcode, d_data, d_source, d_size
//  full   in   1       command FIFO full
//  wr_en  out  1       command FIFO write strobe; din taken at this clock edge
//  din    out  8       command FIFO write byte
//  empty  in   1       response FIFO empty
//  rd_en  out  1       response FIFO read strobe
//  dout   in   8       response FIFO byte, valid the cycle after rd_en (1-cycle read)
// BEHAVIOUR
//  Reset (async, any time, also mid-transaction):
//   - state=IDLE; a_ready=1; d_valid=0; wr_en=0; rd_en=0; din=0; d_data=0.
//   - Byte counters clear; the request in flight is dropped, no D beat issued.
//  FSM, all transitions registered:
//   - IDLE: a_ready=1. a_valid&a_ready with a_opcode==Get(4): latch a_address,
//     a_source, a_size -> CMD. Any other opcode is ignored; stay IDLE.
//   - CMD: wr_en = ~full; din = address byte[cnt], LSB byte first (byte 0 =
//     addr[7:0]). Each write increments cnt (3 bit). Write with cnt==7 -> RSP,
//     cnt=0. full=1 stalls with no write and no byte skipped.
//   - RSP: rd_en = ~empty while fewer than 8 reads issued. Each dout, sampled
//     one cycle after its rd_en, shifts in from the top:
//     data <= {dout, data[63:8]}, so the first byte lands in data[7:0].
//     Exactly 8 reads are issued, never more. empty=1 stalls with no read.
//     After 8th byte captured -> RESP.
//   - RESP: d_valid=1; d_opcode=AccessAckData(1); d_data=assembled word;
//     d_source/d_size = latched values. Held stable until d_ready;
//     d_valid&d_ready -> IDLE.
//  Other rules:
//   - a_ready=0 outside IDLE.
//   - wr_en and rd_en never both high.
//   - Counters wrap 7->0 exactly at a state change.
//   - Best-case latency: A accept to d_valid = 1+8+8+1 = 18 cycles.
//   - Back-to-back Gets: the next A beat can be accepted the cycle after the
//     D handshake.
// STRUCTURE
//  - Package rrom_pkg: TL opcode constants (TL_GET=3'd4,
//    TL_ACCESS_ACK_DATA=3'd1), FSM enum {IDLE,CMD,RSP,RESP}, byte count width.
//  - One sub-module rrom_byte_shifter: 64-bit shift register with byte
//    load/shift-out (cmd) and shift-in (rsp). FSM stays in top.
// TESTING (bench model: echo FIFO, returns the 8 written bytes in order)
//  - Get addr 0x0000_0000_8000_1000: din = 00,10,00,80,00,00,00,00, then
//    d_data = 0x0000_0000_8000_1000, d_opcode=1.
//  - Two back-to-back Gets 0x10, 0x18: two D beats, data 0x10 then 0x18,
//    source echoed per request.
//  - full=1 for 3 cycles after 2nd byte: no wr_en while full, all 8 bytes in
//    order, data intact.
//  - empty toggling during RSP: exactly 8 rd_en pulses; word still assembled
//    LSB-first and correct.
//  - d_ready=0 for 5 cycles: d_valid and d_data held stable; a_ready stays 0
//    until the handshake.
//  - rst_n low during CMD after 4 bytes: outputs at reset values at once;
//    a new Get restarts from byte 0.

Source files
------------

// File: rtl/rrom_pkg.sv
// Shared TileLink constants, widths and FSM states for the remote ROM front end.
package rrom_pkg;
  localparam int TL_ADDR_W = 64;
  localparam int TL_DATA_W = 64;
  localparam int TL_SRC_W  = 4;
  localparam int CNT_W     = 3;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE, CMD, RSP, RESP} state_t;
endpackage

// File: rtl/rrom_frontend_if.sv
// TileLink-UL A/D channel bundle between the system bus and the remote ROM front end.
interface rrom_frontend_if import rrom_pkg::*; #(
  parameter int ADDR_W = TL_ADDR_W,
  parameter int DATA_W = TL_DATA_W,
  parameter int SRC_W  = TL_SRC_W
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [ADDR_W-1:0] a_address;
  logic [SRC_W-1:0]  a_source;
  logic [2:0]        a_size;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [DATA_W-1:0] d_data;
  logic [SRC_W-1:0]  d_source;
  logic [2:0]        d_size;

  modport master (
    output a_valid, a_opcode, a_address, a_source, a_size, d_ready,
    input  a_ready, d_valid, d_opcode, d_data, d_source, d_size
  );

  modport slave (
    input  a_valid, a_opcode, a_address, a_source, a_size, d_ready,
    output a_ready, d_valid, d_opcode, d_data, d_source, d_size
  );
endinterface

// File: rtl/rrom_byte_shifter.sv
// Right-shifting byte register: loads the address and shifts it out LSB first,
// then reuses the same storage to shift response bytes in from the top.
module rrom_byte_shifter import rrom_pkg::*; #(
  parameter int W = TL_DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic         shift_out,
  input  logic         shift_in,
  input  logic [7:0]   in_byte,
  output logic [7:0]   out_byte,
  output logic [W-1:0] word
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (load) begin
      word <= load_dat;
    end else if (shift_out) begin
      word <= {8'h00, word[W-1:8]};
    end else if (shift_in) begin
      word <= {in_byte, word[W-1:8]};
    end
  end

  assign out_byte = word[7:0];
endmodule

// File: rtl/rrom_frontend.sv
// TileLink-UL Get slave: sends the address byte-wise to the command FIFO, gathers
// the response bytes into one AccessAckData beat. One request in flight, 18 cycles best case.
module rrom_frontend import rrom_pkg::*; #(
  parameter int ADDR_W = TL_ADDR_W,
  parameter int DATA_W = TL_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rrom_frontend_if.slave        bus,
  input  logic                  full,
  output logic                  wr_en,
  output logic [7:0]            din,
  input  logic                  empty,
  output logic                  rd_en,
  input  logic [7:0]            dout
);
  localparam int SH_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(ADDR_W / 8 - 1);
  localparam logic [CNT_W-1:0] RSP_LAST = CNT_W'(DATA_W / 8 - 1);
  localparam logic [CNT_W:0]   RD_TOTAL = (CNT_W + 1)'(DATA_W / 8);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W:0]      rd_cnt;
  logic                rd_pend;
  logic                load;
  logic [TL_SRC_W-1:0] src_q;
  logic [2:0]          size_q;
  logic [7:0]          out_byte;
  logic [SH_W-1:0]     word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_cnt  <= '0;
      rd_pend <= 1'b0;
      src_q   <= '0;
      size_q  <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_en;
      // cnt counts writes in CMD and captured bytes in RSP; it wraps on the last one
      if (wr_en || rd_pend) cnt <= cnt + 1'b1;
      if (state != RSP)     rd_cnt <= '0;
      else if (rd_en)       rd_cnt <= rd_cnt + 1'b1;
      if (load) begin
        src_q  <= bus.a_source;
        size_q <= bus.a_size;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bus.a_ready = 1'b0;
    bus.d_valid = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        bus.a_ready = 1'b1;
        if (bus.a_valid && bus.a_opcode == TL_GET) begin
          load      = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        wr_en = !full;
        if (!full && cnt == CMD_LAST) state_nxt = RSP;
      end
      RSP: begin
        // reads may run ahead of captures by one, so cap on issued reads separately
        rd_en = !empty && (rd_cnt != RD_TOTAL);
        if (rd_pend && cnt == RSP_LAST) state_nxt = RESP;
      end
      RESP: begin
        bus.d_valid = 1'b1;
        if (bus.d_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign din          = (state == CMD) ? out_byte : 8'h00;
  assign bus.d_data   = (state == RESP) ? word[SH_W-1 -: DATA_W] : '0;
  assign bus.d_opcode = TL_ACCESS_ACK_DATA;
  assign bus.d_source = src_q;
  assign bus.d_size   = size_q;

  rrom_byte_shifter #(.W(SH_W)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_dat  (SH_W'(bus.a_address)),
    .shift_out (wr_en),
    .shift_in  (rd_pend),
    .in_byte   (dout),
    .out_byte  (out_byte),
    .word      (word)
  );
endmodule

// File: tb/tb_rrom_frontend.sv
// Bench for rrom_frontend: echo FIFO on the byte link, request-level scoreboard on A/D.
module tb_rrom_frontend;
  import rrom_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       full = 1'b0;
  logic       empty = 1'b1;
  logic       wr_en, rd_en;
  logic [7:0] din;
  logic [7:0] dout = 8'h00;

  always #5 clk = ~clk;

  rrom_frontend_if bus();

  rrom_frontend dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .full  (full),
    .wr_en (wr_en),
    .din   (din),
    .empty (empty),
    .rd_en (rd_en),
    .dout  (dout)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] addr;
    logic [3:0]  src;
    logic [2:0]  size;
  } req_t;

  req_t        exp_q[$];
  logic [7:0]  exp_din[$];
  logic [7:0]  din_log[$];
  logic [63:0] d_log[$];
  logic [3:0]  src_log[$];
  bit          busy = 1'b0;
  int          cyc = 0;
  int          rd_cnt_m = 0;
  int          last_rd_cnt = 0;
  int          accept_cyc = 0;
  int          last_dfire_cyc = -100;
  int          last_accept_gap = 0;
  int          last_lat = 0;
  bit          lat_taken = 1'b0;
  int          d_fires = 0;
  int          wr_total = 0;
  int          full_seen = 0;

  bit          rand_full = 1'b0, rand_empty = 1'b0, rand_dready = 1'b0, full_force = 1'b0;
  bit          wr_s = 1'b0, rd_s = 1'b0;
  logic [7:0]  din_s = 8'h00;
  logic [7:0]  fq[$];

  always @(posedge clk) cyc++;

  // Echo FIFO: every written byte comes back in order; dout valid the cycle after rd_en.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      fq.delete();
    end else begin
      if (wr_s) fq.push_back(din_s);
      if (rd_s) begin
        if (fq.size() == 0) timeout_fail("read_from_empty_fifo");
        else dout = fq.pop_front();
      end
    end
    full  = full_force || (rand_full && $urandom_range(0, 3) == 0);
    empty = (fq.size() == 0) || (rand_empty && $urandom_range(0, 1) == 0);
    if (rand_dready) bus.d_ready = ($urandom_range(0, 1) == 1);
  end

  // Compare process: outputs are settled at the falling edge.
  always @(negedge clk) begin
    wr_s = 1'b0;
    rd_s = 1'b0;
    if (rst_n) begin
      chk("wr_rd_exclusive", {63'd0, wr_en && rd_en}, 64'd0);
      chk("a_ready_when_free", {63'd0, bus.a_ready}, {63'd0, !busy});
      if (busy && full) full_seen++;
      if (wr_en) begin
        chk("wr_while_full", {63'd0, full}, 64'd0);
        if (exp_din.size() == 0) timeout_fail("unexpected_wr_en");
        else chk("din_byte", {56'd0, din}, {56'd0, exp_din.pop_front()});
        din_log.push_back(din);
        wr_total++;
        wr_s  = 1'b1;
        din_s = din;
      end
      if (rd_en) begin
        rd_cnt_m++;
        chk("rd_at_most_8", {63'd0, rd_cnt_m <= 8}, 64'd1);
        chk("rd_while_empty", {63'd0, empty}, 64'd0);
        rd_s = 1'b1;
      end
      if (bus.d_valid) begin
        if (exp_q.size() == 0) begin
          timeout_fail("unexpected_d_valid");
        end else begin
          chk("d_data_echo", bus.d_data, exp_q[0].addr);
          chk("d_opcode", {61'd0, bus.d_opcode}, 64'd1);
          chk("d_source", {60'd0, bus.d_source}, {60'd0, exp_q[0].src});
          chk("d_size", {61'd0, bus.d_size}, {61'd0, exp_q[0].size});
          chk("reads_before_d", rd_cnt_m, 8);
          if (!lat_taken) begin
            last_lat  = cyc - accept_cyc;
            lat_taken = 1'b1;
          end
          if (bus.d_ready) begin
            d_log.push_back(bus.d_data);
            src_log.push_back(bus.d_source);
            void'(exp_q.pop_front());
            last_rd_cnt    = rd_cnt_m;
            busy           = 1'b0;
            d_fires++;
            last_dfire_cyc = cyc;
          end
        end
      end
      if (bus.a_valid && bus.a_ready && bus.a_opcode == TL_GET) begin
        req_t r;
        r.addr = bus.a_address;
        r.src  = bus.a_source;
        r.size = bus.a_size;
        exp_q.push_back(r);
        for (int i = 0; i < 8; i++) exp_din.push_back(r.addr[8*i +: 8]);
        busy            = 1'b1;
        rd_cnt_m        = 0;
        lat_taken       = 1'b0;
        last_accept_gap = cyc - last_dfire_cyc;
        accept_cyc      = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic get(input logic [63:0] addr, input logic [3:0] src, input logic [2:0] size,
                     input logic [2:0] op);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_address = addr;
    bus.a_source  = src;
    bus.a_size    = size;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (bus.a_ready) ok = 1'b1;
    end
    if (!ok) timeout_fail("a_handshake");
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic wait_d(input int target);
    bit ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (d_fires >= target) ok = 1'b1;
    end
    if (!ok) timeout_fail("d_handshake");
  endtask

  task automatic wait_wr(input int target);
    bit ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (wr_total >= target) ok = 1'b1;
    end
    if (!ok) timeout_fail("wr_progress");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_ready"}, {63'd0, bus.a_ready}, 64'd1);
    chk({tag, "_d_valid"}, {63'd0, bus.d_valid}, 64'd0);
    chk({tag, "_wr_en"},   {63'd0, wr_en}, 64'd0);
    chk({tag, "_rd_en"},   {63'd0, rd_en}, 64'd0);
    chk({tag, "_din"},     {56'd0, din}, 64'd0);
    chk({tag, "_d_data"},  bus.d_data, 64'd0);
  endtask

  initial begin
    logic [7:0]  exp1[8];
    logic [63:0] held;
    int          base, n_gets;
    bit          ok;

    bus.a_valid = 1'b0; bus.a_opcode = 3'd0; bus.a_address = '0;
    bus.a_source = '0;  bus.a_size = 3'd0;   bus.d_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Single Get, byte order and best-case latency pinned by hand.
    bus.d_ready = 1'b1;
    din_log.delete();
    exp1 = '{8'h00, 8'h10, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    get(64'h0000_0000_8000_1000, 4'h3, 3'd3, TL_GET);
    wait_d(1);
    chk("t1_din_count", din_log.size(), 8);
    for (int i = 0; i < 8 && i < din_log.size(); i++) chk("t1_din_literal", {56'd0, din_log[i]}, {56'd0, exp1[i]});
    chk("t1_d_data_literal", d_log[0], 64'h0000_0000_8000_1000);
    chk("t1_latency", last_lat, 18);

    // Back-to-back Gets.
    d_log.delete(); src_log.delete();
    get(64'h10, 4'h1, 3'd3, TL_GET);
    get(64'h18, 4'h2, 3'd3, TL_GET);
    wait_d(3);
    chk("t2_accept_gap", last_accept_gap, 1);
    chk("t2_beats", d_log.size(), 2);
    if (d_log.size() == 2) begin
      chk("t2_data0", d_log[0], 64'h10);
      chk("t2_data1", d_log[1], 64'h18);
      chk("t2_src0", {60'd0, src_log[0]}, 64'h1);
      chk("t2_src1", {60'd0, src_log[1]}, 64'h2);
    end

    // Command FIFO full for three cycles after the second byte.
    d_log.delete(); din_log.delete(); full_seen = 0;
    base = wr_total;
    get(64'hA5A5_0102_0304_0506, 4'h4, 3'd3, TL_GET);
    wait_wr(base + 2);
    full_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) full_force = 1'b0;
    wait_d(4);
    chk("t3_full_seen", {63'd0, full_seen >= 3}, 64'd1);
    chk("t3_din_count", din_log.size(), 8);
    chk("t3_data", d_log[0], 64'hA5A5_0102_0304_0506);

    // Response FIFO empty toggling.
    d_log.delete();
    @(negedge clk) rand_empty = 1'b1;
    get(64'h0123_4567_89AB_CDEF, 4'h5, 3'd2, TL_GET);
    wait_d(5);
    @(negedge clk) rand_empty = 1'b0;
    chk("t4_rd_pulses", last_rd_cnt, 8);
    chk("t4_data", d_log[0], 64'h0123_4567_89AB_CDEF);

    // D channel stalled for five cycles.
    bus.d_ready = 1'b0;
    get(64'hFEED_FACE_CAFE_0042, 4'h6, 3'd3, TL_GET);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (bus.d_valid) ok = 1'b1;
    end
    if (!ok) timeout_fail("t5_d_valid");
    held = bus.d_data;
    chk("t5_held_literal", held, 64'hFEED_FACE_CAFE_0042);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_d_valid_held", {63'd0, bus.d_valid}, 64'd1);
      chk("t5_d_data_held", bus.d_data, held);
      chk("t5_a_ready_low", {63'd0, bus.a_ready}, 64'd0);
    end
    @(posedge clk); #1 bus.d_ready = 1'b1;
    wait_d(6);

    // Reset in the middle of the command phase.
    base = wr_total;
    get(64'h1111_2222_3333_4444, 4'h7, 3'd3, TL_GET);
    wait_wr(base + 4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete(); exp_din.delete(); busy = 1'b0; rd_cnt_m = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_d_beat", d_fires, 6);
    din_log.delete(); d_log.delete();
    get(64'hDEAD_BEEF_0123_4567, 4'h8, 3'd3, TL_GET);
    wait_d(7);
    if (din_log.size() > 0) chk("midrst_first_byte", {56'd0, din_log[0]}, 64'h67);
    else timeout_fail("midrst_first_byte");
    chk("midrst_data", d_log[0], 64'hDEAD_BEEF_0123_4567);

    // Randomised traffic with link and D-channel backpressure.
    @(negedge clk);
    rand_full = 1'b1; rand_empty = 1'b1; rand_dready = 1'b1;
    n_gets = 0;
    for (int i = 0; i < 25; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : TL_GET;
      if (op == TL_GET) n_gets++;
      get({$urandom, $urandom}, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), op);
    end
    wait_d(7 + n_gets);
    @(negedge clk);
    rand_full = 1'b0; rand_empty = 1'b0; rand_dready = 1'b0;
    chk("rand_d_beats", d_fires, 7 + n_gets);
    chk("rand_scoreboard_empty", exp_q.size(), 0);
    chk("rand_din_drained", exp_din.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end
endmodule
